// File: rtl/lcd_hd44780_pkg.sv
// Shared definitions for the HD44780-compatible LCD responder.
// Holds instruction bit positions and masks, DDRAM geometry, the controller
// state type, and the address-counter helpers: step with line wrap, set-DDRAM
// normalisation, and the mapping from AC to a linear DDRAM index.
package lcd_hd44780_pkg;

  // Instruction opcode bit positions (highest set bit selects the instruction)
  localparam int unsigned BIT_SET_DDRAM = 7;
  localparam int unsigned BIT_SET_CGRAM = 6;
  localparam int unsigned BIT_FUNC_SET  = 5;
  localparam int unsigned BIT_SHIFT     = 4;
  localparam int unsigned BIT_DISP_CTRL = 3;
  localparam int unsigned BIT_ENTRY     = 2;
  localparam int unsigned BIT_HOME      = 1;
  localparam int unsigned BIT_CLEAR     = 0;

  // Field bits inside individual instructions
  localparam int unsigned BIT_SC = 3;  // shift: 1 = display, 0 = cursor
  localparam int unsigned BIT_RL = 2;  // shift: 1 = right (+1)
  localparam int unsigned BIT_ID = 1;  // entry mode: increment
  localparam int unsigned BIT_S  = 0;  // entry mode: display shift

  localparam logic [7:0] MASK_SET_DDRAM = 8'(1) << BIT_SET_DDRAM;
  localparam logic [7:0] MASK_SET_CGRAM = 8'(1) << BIT_SET_CGRAM;
  localparam logic [7:0] MASK_FUNC_SET  = 8'(1) << BIT_FUNC_SET;
  localparam logic [7:0] MASK_SHIFT     = 8'(1) << BIT_SHIFT;
  localparam logic [7:0] MASK_DISP_CTRL = 8'(1) << BIT_DISP_CTRL;
  localparam logic [7:0] MASK_ENTRY     = 8'(1) << BIT_ENTRY;
  localparam logic [7:0] MASK_HOME      = 8'(1) << BIT_HOME;
  localparam logic [7:0] MASK_CLEAR     = 8'(1) << BIT_CLEAR;

  localparam logic [6:0]  LINE1_BASE  = 7'h00;
  localparam logic [6:0]  LINE2_BASE  = 7'h40;
  localparam int unsigned LINE_LEN    = 40;
  localparam int unsigned DDRAM_DEPTH = 80;
  localparam logic [7:0]  CHAR_SPACE  = 8'h20;

  localparam logic [6:0] LINE1_END = LINE1_BASE + 7'(LINE_LEN - 1);
  localparam logic [6:0] LINE2_END = LINE2_BASE + 7'(LINE_LEN - 1);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StClear
  } state_e;

  // Step AC by one position, wrapping between the ends of the two lines.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (ac == LINE1_END)      r = LINE2_BASE;
      else if (ac == LINE2_END) r = LINE1_BASE;
      else                      r = ac + 7'd1;
    end else begin
      if (ac == LINE1_BASE)      r = LINE2_END;
      else if (ac == LINE2_BASE) r = LINE1_END;
      else                       r = ac - 7'd1;
    end
    return r;
  endfunction

  // Column addresses past the end of a line land on the start of the other line.
  function automatic logic [6:0] ddram_set(input logic [6:0] a);
    logic [6:0] r;
    if ({1'b0, a[5:0]} >= 7'(LINE_LEN)) r = a[6] ? LINE1_BASE : LINE2_BASE;
    else                                r = a;
    return r;
  endfunction

  function automatic logic [6:0] lin(input logic [6:0] ac);
    return {1'b0, ac[5:0]} + (ac[6] ? 7'(LINE_LEN) : 7'd0);
  endfunction

endpackage

// File: rtl/lcd_ddram_2p.sv
// 80x8 display data RAM.
//   clk_i, reset_i      : clock, synchronous active-high reset (dbg register only)
//   we_i/waddr_i/wdata_i: single write port
//   raddr_i -> rdata_o  : asynchronous bus read port
//   dbg_addr_i -> dbg_data_o : registered debug read port, 1-cycle latency,
//                              returns old data when colliding with a write
module lcd_ddram_2p
  import lcd_hd44780_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       we_i,
  input  logic [6:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [6:0] raddr_i,
  output logic [7:0] rdata_o,
  input  logic [6:0] dbg_addr_i,
  output logic [7:0] dbg_data_o
);

  logic [7:0] mem_q [DDRAM_DEPTH];
  logic [7:0] dbg_d, dbg_q;

  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i < 7'(DDRAM_DEPTH))) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = (raddr_i < 7'(DDRAM_DEPTH)) ? mem_q[raddr_i] : 8'h00;

  always_comb begin
    dbg_d = 8'h00;
    if (dbg_addr_i < 7'(DDRAM_DEPTH)) dbg_d = mem_q[dbg_addr_i];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) dbg_q <= 8'h00;
    else         dbg_q <= dbg_d;
  end

  assign dbg_data_o = dbg_q;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible responder: the device end of a 16207 character-LCD bus.
// Decodes instruction/data cycles on the falling edge of LCD_E, keeps an
// 80-byte DDRAM, the address counter and busy timing, and answers status and
// data reads.
//   clk, reset         : clock, synchronous active-high reset
//   LCD_E/RS/RW        : bus strobe and cycle type from the master
//   LCD_data_in        : bus value from the master
//   LCD_data_out/_oe   : read response and output enable (tristate built above)
//   busy               : busy flag (BF)
//   proto_err          : one-cycle pulse on a write or data read while busy
//   dbg_addr/dbg_data  : linear DDRAM index and registered contents
module lcd_hd44780_responder
  import lcd_hd44780_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_data_in,
  output logic [7:0] LCD_data_out,
  output logic       LCD_data_oe,
  output logic       busy,
  output logic       proto_err,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam int unsigned MaxCycles = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] BusyLoad  = CntW'(BUSY_CYCLES - 1);
  localparam logic [CntW-1:0] ClearLoad = CntW'(CLEAR_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [6:0]      ac_q, ac_d, fill_q, fill_d;
  logic            id_q, id_d, sh_q, sh_d, cg_q, cg_d;
  logic [2:0]      fn_q, fn_d, dc_q, dc_d;
  logic            e_q, e_d, rs_q, rs_d, rw_q, rw_d;
  logic [7:0]      din_q, din_d;
  logic            oe_q, oe_d, perr_q, perr_d;

  logic            ram_we;
  logic [6:0]      ram_waddr;
  logic [7:0]      ram_wdata, ram_rdata;
  logic            is_busy, e_fall;

  assign is_busy = (state_q != StIdle);
  assign e_fall  = e_q & ~LCD_E;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ac_d      = ac_q;
    fill_d    = fill_q;
    id_d      = id_q;
    sh_d      = sh_q;
    cg_d      = cg_q;
    fn_d      = fn_q;
    dc_d      = dc_q;
    e_d       = LCD_E;
    rs_d      = rs_q;
    rw_d      = rw_q;
    din_d     = din_q;
    oe_d      = LCD_E & LCD_RW;
    perr_d    = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = fill_q;
    ram_wdata = CHAR_SPACE;

    // Cycle type and data are whatever was on the bus in the last E-high cycle.
    if (LCD_E) begin
      rs_d  = LCD_RS;
      rw_d  = LCD_RW;
      din_d = LCD_data_in;
    end

    // Clear fill runs alongside the busy countdown; it always finishes first.
    if (state_q == StClear && fill_q < 7'(DDRAM_DEPTH)) begin
      ram_we = 1'b1;
      fill_d = fill_q + 7'd1;
    end

    if (is_busy) begin
      if (cnt_q == '0) state_d = StIdle;
      else             cnt_d   = cnt_q - CntW'(1);
    end

    if (e_fall) begin
      if (!rw_q) begin
        if (is_busy) begin
          perr_d = 1'b1;
        end else begin
          state_d = StExec;
          cnt_d   = BusyLoad;
          if (rs_q) begin
            // In CGRAM mode data writes are discarded and AC is left alone.
            if (!cg_q) begin
              ram_we    = 1'b1;
              ram_waddr = lin(ac_q);
              ram_wdata = din_q;
              ac_d      = ac_step(ac_q, id_q);
            end
          end else if (|(din_q & MASK_SET_DDRAM)) begin
            ac_d = ddram_set(din_q[6:0]);
            cg_d = 1'b0;
          end else if (|(din_q & MASK_SET_CGRAM)) begin
            cg_d = 1'b1;
          end else if (|(din_q & MASK_FUNC_SET)) begin
            fn_d = din_q[4:2];  // DL, N, F
          end else if (|(din_q & MASK_SHIFT)) begin
            if (!din_q[BIT_SC]) ac_d = ac_step(ac_q, din_q[BIT_RL]);
          end else if (|(din_q & MASK_DISP_CTRL)) begin
            dc_d = din_q[2:0];  // D, C, B
          end else if (|(din_q & MASK_ENTRY)) begin
            id_d = din_q[BIT_ID];
            sh_d = din_q[BIT_S];
          end else if (|(din_q & MASK_HOME)) begin
            ac_d = LINE1_BASE;
          end else if (|(din_q & MASK_CLEAR)) begin
            state_d = StClear;
            cnt_d   = ClearLoad;
            fill_d  = '0;
            ac_d    = LINE1_BASE;
            id_d    = 1'b1;
          end
        end
      end else if (rs_q) begin
        // Data read: the byte was already presented; only the AC step is gated.
        if (is_busy)    perr_d = 1'b1;
        else if (!cg_q) ac_d   = ac_step(ac_q, id_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StClear;
      cnt_q   <= ClearLoad;
      ac_q    <= LINE1_BASE;
      fill_q  <= '0;
      id_q    <= 1'b1;
      sh_q    <= 1'b0;
      cg_q    <= 1'b0;
      fn_q    <= 3'b110;
      dc_q    <= 3'b000;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      din_q   <= 8'h00;
      oe_q    <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ac_q    <= ac_d;
      fill_q  <= fill_d;
      id_q    <= id_d;
      sh_q    <= sh_d;
      cg_q    <= cg_d;
      fn_q    <= fn_d;
      dc_q    <= dc_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      din_q   <= din_d;
      oe_q    <= oe_d;
      perr_q  <= perr_d;
    end
  end

  lcd_ddram_2p u_ddram (
    .clk_i      (clk),
    .reset_i    (reset),
    .we_i       (ram_we),
    .waddr_i    (ram_waddr),
    .wdata_i    (ram_wdata),
    .raddr_i    (lin(ac_q)),
    .rdata_o    (ram_rdata),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  // Combinational so status reads follow BF live while the strobe is held.
  always_comb begin
    LCD_data_out = 8'h00;
    if (oe_q) LCD_data_out = rs_q ? (cg_q ? 8'h00 : ram_rdata) : {is_busy, ac_q};
  end

  assign LCD_data_oe = oe_q;
  assign busy        = is_busy;
  assign proto_err   = perr_q;

endmodule

// File: doc/lcd_hd44780_responder.md
# lcd_hd44780_responder

Synthesizable HD44780-compatible responder for the 16207 character-LCD bus: the far end of the bus driven by the Qsys LCD control slave (LCD_E/LCD_RS/LCD_RW/LCD_data). It decodes instruction and data cycles, maintains an 80-byte DDRAM, an address counter and busy timing, and answers status/data reads. It serves as an on-chip LCD stand-in and as the bench responder for the LCD master, with a debug port that mirrors the display contents.

## Interface
- BUSY_CYCLES, 2000: busy duration after any accepted write except clear (40 µs at 50 MHz).
- CLEAR_CYCLES, 82000: busy duration after clear display or reset (1.64 ms at 50 MHz). Must be ≥ 80.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- LCD_E  in  1  enable strobe from the master.
- LCD_RS  in  1  0 = instruction/status, 1 = data.
- LCD_RW  in  1  0 = write, 1 = read.
- LCD_data_in  in  8  bus value from the master.
- LCD_data_out  out  8  read response.
- LCD_data_oe  out  1  responder drives the bus; the top level builds the tristate.
- busy  out  1  mirror of BF.
- proto_err  out  1  one-cycle pulse: write dropped while busy, or data read while busy.
- dbg_addr  in  7  linear DDRAM index 0..79; 0..39 is line 1, 40..79 is line 2.
- dbg_data  out  8  DDRAM[dbg_addr], registered, 1-cycle latency.

## Operation
- Reset: AC=0, I/D=1, S=0, D=C=B=0, DL=1, N=1. The block enters CLEAR, fills all 80 bytes with 0x20, and BF=1 for CLEAR_CYCLES. Outputs at reset: LCD_data_out=0, LCD_data_oe=0, busy=1, proto_err=0, dbg_data=0.
- State machine:
  - IDLE to EXEC on an accepted write.
  - IDLE to CLEAR on an accepted 0x01.
  - EXEC returns to IDLE when the busy counter reaches 0.
  - CLEAR runs the fill index 0..79 (1 byte/cycle) in parallel with the busy count, then returns to IDLE.
- Writes are accepted on the falling edge of E (e_q=1, LCD_E=0). RS and data are taken from the last cycle E was high. In EXEC or CLEAR the write is dropped and proto_err pulses.
- Instruction decode, highest set bit wins:
  - 0x80 set DDRAM: AC=data[6:0]. 0x28..0x3F maps to 0x40; 0x68..0x7F maps to 0x00.
  - 0x40 set CGRAM: sets cg_mode. Later data writes are discarded and data reads return 0x00 until the next set DDRAM.
  - 0x20 function set: stores DL/N/F. Only 8-bit behaviour is implemented.
  - 0x10 cursor/display shift: if S/C=0, AC±1 (R/L=1 is +1) with wrap. If S/C=1, no state change.
  - 0x08 display control: stores D/C/B.
  - 0x04 entry mode: I/D=bit1, S=bit0 (S stored only).
  - 0x02 return home: AC=0.
  - 0x01 clear: fill, AC=0, I/D=1.
  - 0x00: no operation, still busy BUSY_CYCLES.
- Data write: DDRAM[lin(AC)]=data, then AC steps by I/D.
- AC wrap:
  - Increment: 0x27 to 0x40, 0x67 to 0x00.
  - Decrement: 0x00 to 0x67, 0x40 to 0x27.
- lin(AC) = AC[6] ? 40+AC[5:0] : AC[5:0].
- Reads (RW=1):
  - RS=0 returns {BF, AC}. Always legal; AC is unchanged.
  - RS=1 returns DDRAM[lin(AC)]. AC steps on the falling edge of E.
  - Data read while busy returns the current byte, AC is not stepped, and proto_err pulses.

## Timing
- Inputs are assumed synchronous to clk; no synchronizers.
- E must be high ≥ 2 clk, and low ≥ 1 clk between strobes.
- LCD_data_oe is registered and rises 1 clk after E and RW are both seen high. It falls in the cycle after E falls or RW drops.
- LCD_data_out is valid whenever LCD_data_oe=1. It is re-evaluated each cycle, so status reads track BF live.
- BF rises in the cycle after the accepting falling edge.
- BF falls exactly BUSY_CYCLES (or CLEAR_CYCLES) cycles after it rises.
- Reset asserted mid-EXEC or mid-CLEAR restarts the full clear sequence.
- The dbg port is read-only and independent. If dbg_addr hits the byte being written, old data is returned (read-before-write).

## Structure
- Package lcd_hd44780_pkg holds:
  - opcode bit positions and instruction masks
  - LINE1_BASE=7'h00, LINE2_BASE=7'h40, LINE_LEN=40, DDRAM_DEPTH=80, CHAR_SPACE=8'h20
  - state enum {IDLE, EXEC, CLEAR}
  - AC step/wrap function and lin() function
- Sub-module lcd_ddram_2p holds the 80x8 RAM with one write port, one async bus-read port and one registered dbg read port.

## Test plan
- Reset, hold 10 clk, release; poll status. Expect 0x80 until CLEAR_CYCLES elapse, then 0x00. dbg_data=0x20 at indices 0, 39, 40 and 79.
- Write 0x06, then data 0x41 0x42. Expect status AC=0x02 and DDRAM[0..1]=0x41,0x42.
- Write 0xA7, then data 0x5A. Expect dbg[39]=0x5A and AC=0x40 after the increment. Write 0xE7, data, then status: AC=0x00.
- Write 0x04, then 0x80, then data 0x31. Expect dbg[0]=0x31 and AC=0x67.
- Write a data byte 5 clk after a previous write (while busy). Expect a proto_err pulse, DDRAM unchanged and AC unchanged.
- Write 0xC5 (AC=0x45, dbg index 45). Data-read it with E high 3 clk. Expect LCD_data_oe high in E cycles 2..3 with the stored byte, and AC=0x46 afterwards. Assert reset mid-CLEAR: the fill restarts and BF is held for the full CLEAR_CYCLES.
